// File: rtl/ahb_gpio_irq.sv
// ahb_gpio_irq: AHB-Lite GPIO with synchronised inputs, edge interrupts and input parity check
module ahb_gpio_irq #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [WIDTH:0]    GPIOIN,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic [WIDTH-1:0]  GPIOOUT,
  output logic [WIDTH-1:0]  GPIODIR,
  output logic              IRQ,
  output logic              PARITYERR
);
  logic [WIDTH:0]   sync [SYNC_STAGES];
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] prev, en, pol, st, set, wd, data;
  logic             a_valid, a_write, odd, unused_ok;
  logic [2:0]       a_addr;
  logic [5:0]       we;
  logic [31:0]      rd_val;
  assign s = sync[SYNC_STAGES-1];
  assign wd = HWDATA[WIDTH-1:0];
  assign unused_ok = ^{HADDR, HTRANS, HWDATA};
  assign we = (a_valid & a_write) ? 6'(8'd1 << a_addr) : '0;
  assign set = ~GPIODIR & ((pol & s[WIDTH-1:0] & ~prev) | (~pol & ~s[WIDTH-1:0] & prev));
  assign data = (GPIOOUT & GPIODIR) | (s[WIDTH-1:0] & ~GPIODIR);
  assign HREADYOUT = 1'b1;
  assign IRQ = |(st & en);
  always_comb begin
    rd_val = a_addr == 3'd0 ? 32'(data) :
             a_addr == 3'd1 ? 32'(GPIODIR) :
             a_addr == 3'd2 ? 32'(en) :
             a_addr == 3'd3 ? 32'(pol) :
             a_addr == 3'd4 ? 32'(st) :
             a_addr == 3'd5 ? {31'd0, odd} : 32'd0;
    HRDATA = (a_valid & ~a_write) ? rd_val : 32'd0;
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      prev <= '0;
    end else begin
      sync[0] <= GPIOIN;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= s[WIDTH-1:0];
    end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      GPIOOUT   <= '0;
      GPIODIR   <= '0;
      en        <= '0;
      pol       <= '0;
      st        <= '0;
      odd       <= 1'b0;
      PARITYERR <= 1'b0;
    end else begin
      if (HREADY) begin
        a_valid <= HSEL & HTRANS[1];
        a_write <= HWRITE;
        a_addr  <= HADDR[4:2];
      end
      if (we[0]) GPIOOUT <= wd;
      if (we[1]) GPIODIR <= wd;
      if (we[2]) en <= wd;
      if (we[3]) pol <= wd;
      if (we[5]) odd <= HWDATA[0];
      st <= (st & ~(we[4] ? wd : '0)) | set;
      PARITYERR <= ((^s) ^ odd) | (PARITYERR & ~(we[5] & HWDATA[1]));
    end
endmodule

// File: tb/tb_ahb_gpio_irq.sv
// tb_ahb_gpio_irq: directed self-checking bench for ahb_gpio_irq (WIDTH=16, SYNC_STAGES=2)
module tb_ahb_gpio_irq;
  logic        HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0, HREADY = 1;
  logic [31:0] HADDR = 0, HWDATA = 0;
  logic [1:0]  HTRANS = 0;
  logic [16:0] GPIOIN = 0;
  logic        HREADYOUT, IRQ, PARITYERR;
  logic [31:0] HRDATA, r;
  logic [15:0] GPIOOUT, GPIODIR;
  int checks = 0, failures = 0;

  ahb_gpio_irq #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .GPIOIN(GPIOIN),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIOOUT(GPIOOUT), .GPIODIR(GPIODIR),
    .IRQ(IRQ), .PARITYERR(PARITYERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [2:0] idx, input logic wr);
    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = {27'd0, idx, 2'b00};
  endtask

  task automatic idle();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
  endtask

  // returns at the negedge inside the data phase; the write commits at the next posedge
  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    addr_phase(idx, 1'b1);
    @(negedge HCLK);
    HWDATA = d;
    idle();
  endtask

  task automatic rd(input logic [2:0] idx, output logic [31:0] d);
    addr_phase(idx, 1'b0);
    @(negedge HCLK);
    idle();
    d = HRDATA;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  initial begin
    #2;
    chk("rst_gpioout", 32'(GPIOOUT), 0);
    chk("rst_gpiodir", 32'(GPIODIR), 0);
    chk("rst_irq", 32'(IRQ), 0);
    chk("rst_parerr", 32'(PARITYERR), 0);
    chk("rst_hreadyout", 32'(HREADYOUT), 1);
    chk("rst_hrdata", HRDATA, 0);
    wait_n(2);
    HRESET = 0;

    wr(3'd1, 32'h00FF);
    wr(3'd0, 32'hA5A5);
    chk("dataphase_gpioout_old", 32'(GPIOOUT), 0);
    @(negedge HCLK);
    chk("gpioout", 32'(GPIOOUT), 32'hA5A5);
    chk("gpiodir", 32'(GPIODIR), 32'h00FF);
    GPIOIN = 17'h11234;
    wait_n(3);
    rd(3'd0, r);
    chk("data_mixed", r, 32'h12A5);
    rd(3'd1, r);
    chk("dir_read", r, 32'h00FF);
    chk("parerr_even_ok", 32'(PARITYERR), 0);

    wr(3'd1, 32'h0);
    wr(3'd3, 32'h0008);
    wr(3'd2, 32'h0008);
    rd(3'd4, r);
    chk("status_clear", r, 0);
    @(negedge HCLK);
    GPIOIN = 17'h0123C;
    wait_n(2);
    chk("irq_before_edge", 32'(IRQ), 0);
    @(negedge HCLK);
    chk("irq_rise3", 32'(IRQ), 1);
    rd(3'd4, r);
    chk("status_rise3", r, 32'h0008);
    wr(3'd4, 32'h0008);
    @(negedge HCLK);
    chk("irq_w1c", 32'(IRQ), 0);

    GPIOIN = 17'h1121C;
    wait_n(4);
    chk("irq_masked", 32'(IRQ), 0);
    rd(3'd4, r);
    chk("status_fall5", r, 32'h0020);
    wr(3'd2, 32'h0028);
    chk("irq_before_en", 32'(IRQ), 0);
    @(negedge HCLK);
    chk("irq_en5", 32'(IRQ), 1);

    GPIOIN = 17'h00001;
    wait_n(3);
    chk("parerr_set", 32'(PARITYERR), 1);
    GPIOIN = 17'h10001;
    wait_n(3);
    chk("parerr_sticky", 32'(PARITYERR), 1);
    wr(3'd5, 32'h2);
    @(negedge HCLK);
    chk("parerr_clr", 32'(PARITYERR), 0);
    wait_n(2);
    chk("parerr_stays_clr", 32'(PARITYERR), 0);
    wr(3'd5, 32'h1);
    @(negedge HCLK);
    chk("parerr_odd_pending", 32'(PARITYERR), 0);
    @(negedge HCLK);
    chk("parerr_odd_set", 32'(PARITYERR), 1);
    rd(3'd5, r);
    chk("parcfg_read", r, 32'h1);
    wr(3'd5, 32'h3);
    wait_n(2);
    chk("parerr_set_wins", 32'(PARITYERR), 1);

    wr(3'd1, 32'hFFFF);
    addr_phase(3'd0, 1'b1);
    @(negedge HCLK);
    HWDATA = 32'h0F0F; HWRITE = 0;
    @(negedge HCLK);
    idle();
    chk("b2b_hrdata", HRDATA, 32'h0F0F);
    chk("b2b_hreadyout", 32'(HREADYOUT), 1);
    chk("b2b_gpioout", 32'(GPIOOUT), 32'h0F0F);

    @(negedge HCLK);
    HSEL = 1; HTRANS = 2'b00; HWRITE = 1; HADDR = 0;
    @(negedge HCLK);
    HWDATA = 32'hFFFF; HSEL = 0; HTRANS = 2'b10;
    @(negedge HCLK);
    idle();
    @(negedge HCLK);
    chk("idle_nsel_ignored", 32'(GPIOOUT), 32'h0F0F);
    wr(3'd6, 32'hFFFF);
    rd(3'd6, r);
    chk("unmapped_read", r, 0);

    wr(3'd0, 32'h5555);
    #1 HRESET = 1;
    #2;
    chk("midrst_gpioout", 32'(GPIOOUT), 0);
    chk("midrst_hrdata", HRDATA, 0);
    chk("midrst_irq", 32'(IRQ), 0);
    @(negedge HCLK);
    HRESET = 0;
    wait_n(3);
    chk("postrst_gpioout", 32'(GPIOOUT), 0);
    chk("postrst_gpiodir", 32'(GPIODIR), 0);
    chk("postrst_parerr", 32'(PARITYERR), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
